us: RTL and testbench

//   Integer-factor up-sampler for one baseband rail (I or Q) following the signal mapper.

---
 rtl/us.sv | 66 ++++++
 tb/tb_us.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/us.sv
// rtl/us.sv - integer-factor up-sampler for one baseband rail
//
// Purpose:
//   Takes one mapped symbol every FACTOR clocks and emits FACTOR samples per symbol.
//   The first sample is the symbol itself. The remaining FACTOR-1 samples are fill samples.
//   A fill sample is ZERO_CODE when HOLD_MODE=0, or a repeat of the symbol when HOLD_MODE=1.
//   The block runs in the fast (FACTOR x symbol rate) clock domain.
//
// Ports:
//   clk    in   1       sample clock; all state changes on the rising edge
//   reset  in   1       synchronous active-low reset
//   en     in   1       1 = advance the phase and emit samples; 0 = freeze the phase, output ZERO_CODE
//   din    in   DATA_W  mapped symbol; sampled only at phase 0
//   dout   out  DATA_W  up-sampled stream, one registered sample per clk
module us #(
  parameter int                DATA_W    = 2,
  parameter int                FACTOR    = 4,
  parameter int                HOLD_MODE = 0,
  parameter logic [DATA_W-1:0] ZERO_CODE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int              PH_W    = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  // An explicit terminal count lets the phase wrap correctly for non-power-of-two FACTOR.
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FACTOR - 1);

  logic [PH_W-1:0]   ph_q,   ph_d;
  logic [DATA_W-1:0] sym_q,  sym_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  always_comb begin
    ph_d   = ph_q;
    sym_d  = sym_q;
    dout_d = ZERO_CODE;
    if (en) begin
      if (ph_q == '0) begin
        // Phase 0 is the only point where din is consumed.
        sym_d  = din;
        dout_d = din;
      end else begin
        dout_d = (HOLD_MODE != 0) ? sym_q : ZERO_CODE;
      end
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ph_q   <= '0;
      sym_q  <= ZERO_CODE;
      dout_q <= ZERO_CODE;
    end else begin
      ph_q   <= ph_d;
      sym_q  <= sym_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_us.sv
// tb/tb_us.sv - scoreboard bench for us, zero-stuffing and hold instances side by side
module tb_us;

  localparam int F = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic [1:0] din   = 2'b00;
  logic [1:0] dout_zs;
  logic [1:0] dout_hd;

  always #5 clk = ~clk;

  us #(.DATA_W(2), .FACTOR(F), .HOLD_MODE(0), .ZERO_CODE(2'b00)) u_zs (
    .clk(clk), .reset(reset), .en(en), .din(din), .dout(dout_zs)
  );
  us #(.DATA_W(2), .FACTOR(F), .HOLD_MODE(1), .ZERO_CODE(2'b00)) u_hd (
    .clk(clk), .reset(reset), .en(en), .din(din), .dout(dout_hd)
  );

  typedef struct {
    logic [1:0] z;
    logic [1:0] h;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model.
  // m_pos is how many samples of the current symbol have been emitted, modulo F.
  int         m_pos = 0;
  logic [1:0] m_sym = 2'b00;

  task automatic model(input logic r, input logic e, input logic [1:0] d,
                       output logic [1:0] z, output logic [1:0] h);
    if (!r) begin
      m_pos = 0;
      m_sym = 2'b00;
      z = 2'b00;
      h = 2'b00;
    end else if (!e) begin
      z = 2'b00;
      h = 2'b00;
    end else begin
      if (m_pos == 0) begin
        m_sym = d;
        z = d;
        h = d;
      end else begin
        z = 2'b00;
        h = m_sym;
      end
      m_pos = (m_pos + 1) % F;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] d, input string tag);
    exp_t x;
    @(negedge clk);
    reset = r;
    en    = e;
    din   = d;
    model(r, e, d, x.z, x.h);
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
  endtask

  // Directed step: the expectation comes from a literal table, while the model still tracks state.
  task automatic step_tab(input logic [1:0] d, input logic [1:0] ez, input logic [1:0] eh,
                          input string tag);
    exp_t       x;
    logic [1:0] mz;
    logic [1:0] mh;
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    din   = d;
    model(1'b1, 1'b1, d, mz, mh);
    x.z   = ez;
    x.h   = eh;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
  endtask

  // Monitor: one sample per clk, checked away from the edge.
  always @(posedge clk) begin
    exp_t x;
    #2;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checks++;
      if (dout_zs !== x.z) begin
        errors++;
        $display("FAIL %s zs: dout=%b expected %b at %0t", x.tag, dout_zs, x.z, $time);
      end
      checks++;
      if (dout_hd !== x.h) begin
        errors++;
        $display("FAIL %s hold: dout=%b expected %b at %0t", x.tag, dout_hd, x.h, $time);
      end
    end
  end

  logic [1:0] syms[3]  = '{2'b01, 2'b11, 2'b10};
  logic [1:0] tab_z[12] = '{2'b01, 2'b00, 2'b00, 2'b00,
                            2'b11, 2'b00, 2'b00, 2'b00,
                            2'b10, 2'b00, 2'b00, 2'b00};
  logic [1:0] tab_h[12] = '{2'b01, 2'b01, 2'b01, 2'b01,
                            2'b11, 2'b11, 2'b11, 2'b11,
                            2'b10, 2'b10, 2'b10, 2'b10};

  initial begin
    logic [1:0] s;

    // Reset held with en=1 and din=11: no capture, output stays zero.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b11, "reset");

    // Directed sequence; the first released edge is phase 0.
    for (int i = 0; i < 12; i++) step_tab(syms[i/4], tab_z[i], tab_h[i], "directed");

    // Enable gap after the phase-1 sample; din churn during the gap must be ignored.
    s = 2'($urandom);
    step(1'b1, 1'b1, s, "gap_sym");
    step(1'b1, 1'b1, s, "gap_ph1");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'($urandom), "gap_off");
    step(1'b1, 1'b1, 2'($urandom), "gap_fill2");
    step(1'b1, 1'b1, 2'($urandom), "gap_fill3");
    for (int i = 0; i < F; i++) step(1'b1, 1'b1, 2'b11, "gap_next");

    // Reset arriving at phase 2, then release with one idle clock before en returns.
    step(1'b1, 1'b1, 2'b10, "mrst_sym");
    step(1'b1, 1'b1, 2'b01, "mrst_ph1");
    step(1'b0, 1'b1, 2'b01, "mrst_rst");
    step(1'b1, 1'b0, 2'b11, "mrst_idle");
    for (int i = 0; i < F; i++) step(1'b1, 1'b1, 2'b01, "mrst_first");

    // Stream of 512 random symbols, each held F clocks.
    for (int n = 0; n < 512; n++) begin
      s = 2'($urandom);
      for (int i = 0; i < F; i++) step(1'b1, 1'b1, s, "stream");
    end

    // Random mix of enable gaps, occasional resets and din churn.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), 2'($urandom), "mixed");
    end

    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
